// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding types: immediate formats, error codes, immediate limits.
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 32;
  localparam int unsigned COUNT_W = 16;

  // Same coding as the core's ImmSrc select
  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_J = 2'b11
  } fmt_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_BOTH  = 2'b11;

  // Signed immediate limits; B/J limits are byte offsets with bit 0 clear
  localparam logic signed [IMM_W-1:0] IMM_IS_MIN = -32'sd2048;
  localparam logic signed [IMM_W-1:0] IMM_IS_MAX =  32'sd2047;
  localparam logic signed [IMM_W-1:0] IMM_B_MIN  = -32'sd4096;
  localparam logic signed [IMM_W-1:0] IMM_B_MAX  =  32'sd4094;
  localparam logic signed [IMM_W-1:0] IMM_J_MIN  = -32'sd1048576;
  localparam logic signed [IMM_W-1:0] IMM_J_MAX  =  32'sd1048574;

  // One encode request
  typedef struct packed {
    fmt_e             fmt;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [IMM_W-1:0] imm;
  } req_t;

endpackage

// File: rtl/imm_pack.sv
// Combinational instruction packer: places the immediate and register fields
// for the selected format and flags out-of-range or misaligned immediates.
module imm_pack
  import riscv_pkg::*;
(
  input  req_t               req,
  output logic [INSTR_W-1:0] instr_c,
  output logic [1:0]         err_c
);

  logic signed [IMM_W-1:0] imm_s;
  logic                    range_bad;
  logic                    align_bad;

  assign imm_s = $signed(req.imm);

  // Format mux and range/alignment check
  always_comb begin
    instr_c   = '0;
    range_bad = 1'b0;
    align_bad = 1'b0;
    unique case (req.fmt)
      FMT_I: begin
        instr_c   = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        range_bad = (imm_s < IMM_IS_MIN) || (imm_s > IMM_IS_MAX);
      end
      FMT_S: begin
        instr_c   = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
        range_bad = (imm_s < IMM_IS_MIN) || (imm_s > IMM_IS_MAX);
      end
      FMT_B: begin
        instr_c   = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                     req.imm[4:1], req.imm[11], req.opcode};
        range_bad = (imm_s < IMM_B_MIN) || (imm_s > IMM_B_MAX);
        align_bad = req.imm[0];
      end
      FMT_J: begin
        instr_c   = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
        range_bad = (imm_s < IMM_J_MIN) || (imm_s > IMM_J_MAX);
        align_bad = req.imm[0];
      end
    endcase
    err_c = {align_bad, range_bad};
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: two-stage valid/ready pipeline that packs
// request fields into instruction words, tags each with an incrementing
// address, and drops illegal requests with a one-cycle error pulse.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_fmt,
  input  logic [6:0]         in_opcode,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [2:0]         in_funct3,
  input  logic [IMM_W-1:0]   in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               err_valid,
  output logic [1:0]         err_code,
  output logic [COUNT_W-1:0] count
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  req_t               req_c;
  logic [INSTR_W-1:0] enc_instr_c;
  logic [1:0]         enc_err_c;

  logic               s1_valid;
  logic [INSTR_W-1:0] s1_instr;
  logic [1:0]         s1_err;
  logic [ADDR_W-1:0]  counter;

  logic               stall_c;
  logic               accept_c;
  logic               s1_good_c;
  logic               adv_c;
  logic               reject_c;
  logic [ADDR_W-1:0]  addr_sel_c;

  // Gather the request ports into one payload
  always_comb begin
    req_c        = '0;
    req_c.fmt    = fmt_e'(in_fmt);
    req_c.opcode = in_opcode;
    req_c.rd     = in_rd;
    req_c.rs1    = in_rs1;
    req_c.rs2    = in_rs2;
    req_c.funct3 = in_funct3;
    req_c.imm    = in_imm;
  end

  imm_pack u_imm_pack (
    .req     (req_c),
    .instr_c (enc_instr_c),
    .err_c   (enc_err_c)
  );

  assign stall_c    = out_valid & ~out_ready;
  assign in_ready   = ~stall_c;
  assign accept_c   = in_valid & ~stall_c;
  assign s1_good_c  = s1_valid & (s1_err == ERR_NONE);
  assign adv_c      = ~stall_c & s1_good_c;
  assign reject_c   = ~stall_c & s1_valid & (s1_err != ERR_NONE);
  // A start in the same cycle as an advance gives the advancing word base_addr
  assign addr_sel_c = start ? base_addr : counter;

  // Stage 1: capture encoded word and check result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_err   <= ERR_NONE;
    end else if (!stall_c) begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_instr <= enc_instr_c;
        s1_err   <= enc_err_c;
      end
    end
  end

  // Stage 2: output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
    end else if (!stall_c) begin
      out_valid <= s1_good_c;
      if (s1_good_c) begin
        out_instr <= s1_instr;
        out_addr  <= addr_sel_c;
      end
    end
  end

  // Address counter and saturating emitted-word count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      count   <= '0;
    end else if (adv_c) begin
      counter <= addr_sel_c + ADDR_W'(ADDR_STEP);
      if (start) begin
        count <= COUNT_W'(1);
      end else if (count != COUNT_MAX) begin
        count <= count + COUNT_W'(1);
      end
    end else if (start) begin
      counter <= base_addr;
      count   <= '0;
    end
  end

  // Error pulse as a rejected request leaves stage 1; code held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      err_valid <= reject_c;
      if (reject_c) begin
        err_code <= s1_err;
      end
    end
  end

endmodule
